goa_host_bridge: RTL
====================

Name: goa_host_bridge

Overview:
- Byte-serial host bridge directly downstream of the tt_um_scorbetta_goa pin boundary.
- Converts an 8-bit pin bus (ui_in data, uio_in[0] strobe) into single-cycle register write/read requests to the GOA core.
- Returns read data byte-wise on uo_out.
- Gives the chip-level bench one command protocol for every core register.

Parameters:
- DATA_W, 16, register data width; must be a multiple of 8, range 8..32.
- ADDR_W, 7, register address width; must be 7 or less.
- RD_TIMEOUT, 15, cycles to wait for reg_rvalid after reg_re before aborting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- ena  in  1  design enable; low forces IDLE
- pin_data  in  8  host byte (ui_in)
- pin_strobe  in  1  host byte strobe, asynchronous (uio_in[0])
- pin_out  out  8  readback byte (uo_out)
- pin_busy  out  1  high while bridge ignores strobes
- pin_err  out  1  sticky error flag
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  DATA_W  write data
- reg_we  out  1  write pulse
- reg_re  out  1  read pulse
- reg_rdata  in  DATA_W  read data
- reg_rvalid  in  1  read data valid, one cycle

Behaviour:
- Clock, reset and constants:
  - Reset is asynchronous and active-low on rst_n; single clock clk.
  - All outputs reset to 0; FSM resets to IDLE.
  - NB = DATA_W/8.
- Strobe synchronisation and byte capture:
  - pin_strobe passes through a 2-FF synchroniser, then a rising-edge detector.
  - pin_data is registered in parallel through 2 FFs so it stays aligned with the strobe.
  - A byte is "accepted" in the cycle the edge is detected, i.e. 3 clk after the pin rises.
  - Host holds pin_data stable from the strobe rise until 4 clk later.
- Command byte:
  - bit7=1 means write; bit7=0 means read.
  - bits[ADDR_W-1:0] give the address; unused bits are ignored.
- FSM states: IDLE, WR_DATA, WR_COMMIT, RD_REQ, RD_WAIT, RD_DATA.
- IDLE:
  - Accepted byte is latched as the command: reg_addr loaded from the address field.
  - bit7=1 goes to WR_DATA with byte counter 0.
  - bit7=0 goes to RD_REQ.
- WR_DATA:
  - Each accepted byte fills reg_wdata[8k+7:8k], LSB byte first.
  - After the NB-th byte, go to WR_COMMIT.
- WR_COMMIT:
  - reg_we=1 for exactly one cycle with stable addr/wdata, then IDLE.
- RD_REQ:
  - reg_re=1 for exactly one cycle, then RD_WAIT.
- RD_WAIT:
  - On reg_rvalid, capture reg_rdata into the shift register and go to RD_DATA.
  - After RD_TIMEOUT cycles without reg_rvalid: set pin_err, load 0, go to RD_DATA.
- RD_DATA:
  - pin_out = byte 0 (LSB) in the cycle of entry.
  - Each accepted strobe advances to the next byte.
  - The strobe that acknowledges byte NB-1 sets pin_out=0 and returns to IDLE.
- pin_busy = 1 in WR_COMMIT, RD_REQ and RD_WAIT; strobes detected in those states are dropped.
- pin_err:
  - Set only by timeout (or by checksum, see Optional Feature).
  - Cleared only by reset or ena low.
- ena low, any state:
  - Next cycle: FSM in IDLE, counters cleared, pin_out=0, pin_err=0.
  - No reg_we or reg_re is issued; a partial write is discarded.
  - Synchroniser flops keep running.
- reg_rvalid outside RD_WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE with all outputs 0; no pending pulse emitted after release.

Optional Feature:
- Macro GOA_BRIDGE_CHECKSUM_EN.
- When defined:
  - Each write takes one extra byte after the data bytes: the XOR of the command byte and all data bytes.
  - If it matches, proceed to WR_COMMIT.
  - If it mismatches, set pin_err, return to IDLE, and issue no reg_we.
- When undefined: no checksum byte; write commits after the NB-th data byte.
- Reads are unaffected in both builds.

Decomposition:
- Package goa_bridge_pkg holds:
  - FSM state typedef;
  - CMD_WR_BIT = 7;
  - BYTE_W = 8;
  - NB derivation function.
- One sub-module, goa_strobe_sync: 2-FF synchroniser, edge detector and aligned data register; outputs byte_valid and byte_data.

Test Plan (DATA_W=16, ADDR_W=7, RD_TIMEOUT=15):
- Write: strobe 0x85, 0x34, 0x12 → exactly one reg_we pulse, reg_addr=0x05, reg_wdata=0x1234, one cycle after the third byte is accepted.
- Read: strobe 0x05; model returns reg_rdata=0xBEEF with reg_rvalid 2 cycles after reg_re → pin_out=0xEF, then 0xBE after next strobe, then 0x00 after following strobe; pin_err=0.
- Timeout: strobe 0x0A, never assert reg_rvalid → pin_busy high 16 cycles, pin_err=1, pin_out=0x00 for both bytes; ena low clears pin_err.
- Abort: strobe 0x85, 0x34, drop ena for 1 cycle, restore, strobe 0x03 → no reg_we ever; one reg_re with reg_addr=0x03.
- Busy drop: strobes during RD_WAIT produce no byte advance; only post-capture strobes shift pin_out.
- Checksum build: 0x85, 0x34, 0x12, 0xA3 → reg_we with wdata 0x1234; 0x85, 0x34, 0x12, 0x00 → no reg_we, pin_err=1.

Source files
------------

// File: rtl/goa_bridge_pkg.sv
// goa_bridge_pkg: shared types and constants for the GOA host bridge.
// Optional checksum build: GOA_BRIDGE_CHECKSUM_EN.
package goa_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_COMMIT,
    RD_REQ,
    RD_WAIT,
    RD_DATA
  } state_t;

  localparam int CMD_WR_BIT = 7;
  localparam int BYTE_W     = 8;

  function automatic int nb_of(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/goa_strobe_sync.sv
// goa_strobe_sync: 2-FF strobe synchroniser, rising-edge detector and
// data register kept in step with the synchronised strobe.
module goa_strobe_sync
  import goa_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pin_strobe,
  input  logic [BYTE_W-1:0] pin_data,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data
);

  logic              s1, s2, s3;
  logic [BYTE_W-1:0] d1, d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      s1 <= pin_strobe;
      s2 <= s1;
      s3 <= s2;
      d1 <= pin_data;
      d2 <= d1;
    end
  end

  assign byte_valid = s2 & ~s3;
  assign byte_data  = d2;

endmodule

// File: rtl/goa_host_bridge.sv
// goa_host_bridge: byte-serial pin bus to single-cycle register requests.
// Define GOA_BRIDGE_CHECKSUM_EN to require an XOR checksum byte per write.
module goa_host_bridge
  import goa_bridge_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 7,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        pin_data,
  input  logic              pin_strobe,
  output logic [7:0]        pin_out,
  output logic              pin_busy,
  output logic              pin_err,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rvalid
);

  localparam int NB = nb_of(DATA_W);
  localparam logic [2:0] LAST_B = 3'(NB - 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(RD_TIMEOUT - 1);
`ifdef GOA_BRIDGE_CHECKSUM_EN
  localparam logic [2:0] CSUM_B = 3'(NB);
`endif

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  state_t            state;
  logic [2:0]        bcnt;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] sh;
`ifdef GOA_BRIDGE_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  goa_strobe_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_strobe (pin_strobe),
    .pin_data   (pin_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

  // sh holds only the bytes not yet presented on pin_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcnt      <= '0;
      tcnt      <= '0;
      sh        <= '0;
      pin_out   <= '0;
      pin_busy  <= 1'b0;
      pin_err   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
`ifdef GOA_BRIDGE_CHECKSUM_EN
      csum      <= '0;
`endif
    end else if (!ena) begin
      state    <= IDLE;
      bcnt     <= '0;
      tcnt     <= '0;
      sh       <= '0;
      pin_out  <= '0;
      pin_busy <= 1'b0;
      pin_err  <= 1'b0;
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
`ifdef GOA_BRIDGE_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (byte_valid) begin
            reg_addr <= byte_data[ADDR_W-1:0];
            bcnt     <= '0;
`ifdef GOA_BRIDGE_CHECKSUM_EN
            csum     <= byte_data;
`endif
            if (byte_data[CMD_WR_BIT]) begin
              state <= WR_DATA;
            end else begin
              state    <= RD_REQ;
              reg_re   <= 1'b1;
              pin_busy <= 1'b1;
            end
          end
        end
        WR_DATA: begin
          if (byte_valid) begin
`ifdef GOA_BRIDGE_CHECKSUM_EN
            if (bcnt == CSUM_B) begin
              if (csum == byte_data) begin
                state    <= WR_COMMIT;
                reg_we   <= 1'b1;
                pin_busy <= 1'b1;
              end else begin
                pin_err <= 1'b1;
                state   <= IDLE;
              end
            end else begin
              for (int k = 0; k < NB; k++)
                if (bcnt == 3'(k))
                  reg_wdata[k*BYTE_W +: BYTE_W] <= byte_data;
              csum <= csum ^ byte_data;
              bcnt <= bcnt + 3'd1;
            end
`else
            for (int k = 0; k < NB; k++)
              if (bcnt == 3'(k))
                reg_wdata[k*BYTE_W +: BYTE_W] <= byte_data;
            if (bcnt == LAST_B) begin
              state    <= WR_COMMIT;
              reg_we   <= 1'b1;
              pin_busy <= 1'b1;
            end else begin
              bcnt <= bcnt + 3'd1;
            end
`endif
          end
        end
        WR_COMMIT: begin
          reg_we   <= 1'b0;
          pin_busy <= 1'b0;
          state    <= IDLE;
        end
        RD_REQ: begin
          reg_re <= 1'b0;
          tcnt   <= '0;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (reg_rvalid) begin
            sh       <= reg_rdata >> BYTE_W;
            pin_out  <= reg_rdata[BYTE_W-1:0];
            bcnt     <= '0;
            pin_busy <= 1'b0;
            state    <= RD_DATA;
          end else if (tcnt == T_LAST) begin
            pin_err  <= 1'b1;
            sh       <= '0;
            pin_out  <= '0;
            bcnt     <= '0;
            pin_busy <= 1'b0;
            state    <= RD_DATA;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RD_DATA: begin
          if (byte_valid) begin
            if (bcnt == LAST_B) begin
              pin_out <= '0;
              state   <= IDLE;
            end else begin
              pin_out <= sh[BYTE_W-1:0];
              sh      <= sh >> BYTE_W;
              bcnt    <= bcnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
